// File: rtl/barcos_pkg.sv
// Shared types and helpers for the ship placement block: FSM states,
// default board/fleet sizes and the row-major cell index.
package barcos_pkg;

  localparam int MAX_BARCOS_DEF = 5;
  localparam int GRID_DEF       = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PLACE  = 3'd2,
    CHECK  = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } estado_t;

  // Occupancy bit index of a cell; bit = row*grid + col.
  function automatic int cell_idx(input int row, input int col, input int grid);
    return row * grid + col;
  endfunction

endpackage

// File: rtl/huella_barco.sv
// Footprint of a ship: len cells from (row,col) along the orientation,
// as an occupancy-style mask plus a flag saying every cell is on the board.
module huella_barco
  import barcos_pkg::*;
#(
  parameter int GRID       = GRID_DEF,
  parameter int MAX_BARCOS = MAX_BARCOS_DEF
) (
  input  logic [$clog2(GRID)-1:0] row,
  input  logic [$clog2(GRID)-1:0] col,
  input  logic [2:0]              len,
  input  logic                    vertical,
  output logic [GRID*GRID-1:0]    mask,
  output logic                    in_bounds
);

  int r;
  int c;

  always_comb begin
    mask      = '0;
    in_bounds = 1'b1;
    r         = 0;
    c         = 0;
    for (int i = 0; i < MAX_BARCOS; i++) begin
      if (i < int'(len)) begin
        r = int'(row) + (vertical ? i : 0);
        c = int'(col) + (vertical ? 0 : i);
        // Off-board cells are dropped from the mask and flagged instead.
        if (r >= GRID || c >= GRID) in_bounds = 1'b0;
        else mask[cell_idx(r, c, GRID)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/colocador_barcos.sv
// Sequences placement of the player's fleet, largest ship first, and keeps
// the committed occupancy bitmap. Buttons are one-cycle pulses, at most one acted on per cycle.
module colocador_barcos
  import barcos_pkg::*;
#(
  parameter int MAX_BARCOS = MAX_BARCOS_DEF,
  parameter int GRID       = GRID_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              num_barcos,
  input  logic                    start,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_rot,
  input  logic                    btn_ok,
  output logic [$clog2(GRID)-1:0] cur_row,
  output logic [$clog2(GRID)-1:0] cur_col,
  output logic                    vertical,
  output logic [2:0]              ship_len,
  output logic [2:0]              ships_left,
  output logic [GRID*GRID-1:0]    occupancy,
  output logic                    place_error,
  output logic                    done,
  output logic [2:0]              dbg_state
);

  localparam int CW = $clog2(GRID);
  localparam logic [CW-1:0] LAST = CW'(GRID - 1);

  estado_t              state;
  logic [GRID*GRID-1:0] footprint;
  logic                 fits;
  logic [2:0]           n_clamp;

  assign dbg_state = state;

  huella_barco #(
    .GRID       (GRID),
    .MAX_BARCOS (MAX_BARCOS)
  ) u_huella (
    .row       (cur_row),
    .col       (cur_col),
    .len       (ship_len),
    .vertical  (vertical),
    .mask      (footprint),
    .in_bounds (fits)
  );

  always_comb begin
    n_clamp = num_barcos;
    if (num_barcos == 3'd0) n_clamp = 3'd1;
    else if (int'(num_barcos) > MAX_BARCOS) n_clamp = 3'(MAX_BARCOS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_row     <= '0;
      cur_col     <= '0;
      vertical    <= 1'b0;
      ship_len    <= 3'd0;
      ships_left  <= 3'd0;
      occupancy   <= '0;
      place_error <= 1'b0;
      done        <= 1'b0;
    end else begin
      place_error <= 1'b0;
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: begin
          ships_left <= n_clamp;
          ship_len   <= n_clamp;
          cur_row    <= '0;
          cur_col    <= '0;
          vertical   <= 1'b0;
          state      <= PLACE;
        end
        PLACE: begin
          // Fixed priority: ok > rot > up > down > left > right; moves saturate.
          if (btn_ok) state <= CHECK;
          else if (btn_rot) vertical <= ~vertical;
          else if (btn_up) begin
            if (cur_row != '0) cur_row <= cur_row - CW'(1);
          end else if (btn_down) begin
            if (cur_row != LAST) cur_row <= cur_row + CW'(1);
          end else if (btn_left) begin
            if (cur_col != '0) cur_col <= cur_col - CW'(1);
          end else if (btn_right) begin
            if (cur_col != LAST) cur_col <= cur_col + CW'(1);
          end
        end
        CHECK: begin
          if (!fits || (footprint & occupancy) != '0) begin
            place_error <= 1'b1;
            state       <= PLACE;
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          occupancy  <= occupancy | footprint;
          ships_left <= ships_left - 3'd1;
          ship_len   <= ship_len - 3'd1;
          cur_row    <= '0;
          cur_col    <= '0;
          vertical   <= 1'b0;
          if (ships_left == 3'd1) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= PLACE;
          end
        end
        DONE: begin
          done     <= 1'b1;
          ship_len <= 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colocador_barcos.sv
// Directed bench for colocador_barcos on the default 5x5 board, 5-ship maximum.
module tb_colocador_barcos;

  logic        clk;
  logic        rst;
  logic [2:0]  num_barcos;
  logic        start;
  logic        btn_up, btn_down, btn_left, btn_right, btn_rot, btn_ok;
  logic [2:0]  cur_row, cur_col;
  logic        vertical;
  logic [2:0]  ship_len, ships_left;
  logic [24:0] occupancy;
  logic        place_error, done;
  logic [2:0]  dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  colocador_barcos dut (
    .clk         (clk),
    .rst         (rst),
    .num_barcos  (num_barcos),
    .start       (start),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_rot     (btn_rot),
    .btn_ok      (btn_ok),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .vertical    (vertical),
    .ship_len    (ship_len),
    .ships_left  (ships_left),
    .occupancy   (occupancy),
    .place_error (place_error),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input logic l,
                       input logic r, input logic rot, input logic ok);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_rot = rot; btn_ok = ok;
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_rot = 0; btn_ok = 0;
  endtask

  task automatic begin_fleet(input logic [2:0] n);
    rst = 1; start = 0;
    tick();
    rst = 0;
    num_barcos = n;
    start = 1;
    tick();
    tick();
    start = 0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1; start = 0; num_barcos = 3'd0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_rot = 0; btn_ok = 0;
    tick();
    tick();
    vectors++; if (cur_row !== 3'd0) begin miscompares++; $display("FAIL reset_row got %0d exp 0", cur_row); end
    vectors++; if (cur_col !== 3'd0) begin miscompares++; $display("FAIL reset_col got %0d exp 0", cur_col); end
    vectors++; if (ship_len !== 3'd0) begin miscompares++; $display("FAIL reset_len got %0d exp 0", ship_len); end
    vectors++; if (ships_left !== 3'd0) begin miscompares++; $display("FAIL reset_left got %0d exp 0", ships_left); end
    vectors++; if (occupancy !== 25'h0) begin miscompares++; $display("FAIL reset_occ got %h exp 0", occupancy); end
    vectors++; if ({done, place_error, vertical} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {done, place_error, vertical}); end
    rst = 0;
  endtask

  task automatic test_start();
    num_barcos = 3'd3;
    start = 1;
    tick();
    btn_right = 1;   // arrives during LOAD, must be dropped
    tick();
    btn_right = 0;
    vectors++; if (ship_len !== 3'd3) begin miscompares++; $display("FAIL start_len got %0d exp 3", ship_len); end
    vectors++; if (ships_left !== 3'd3) begin miscompares++; $display("FAIL start_left got %0d exp 3", ships_left); end
    vectors++; if ({cur_row, cur_col} !== 6'd0) begin miscompares++; $display("FAIL start_cursor got (%0d,%0d) exp (0,0)", cur_row, cur_col); end
    vectors++; if (occupancy !== 25'h0 || done !== 1'b0) begin miscompares++; $display("FAIL start_occ_done got %h/%b exp 0/0", occupancy, done); end
  endtask

  task automatic test_horizontal();
    press(0, 0, 0, 1, 0, 0);
    vectors++; if (cur_col !== 3'd1) begin miscompares++; $display("FAIL horiz_move got %0d exp 1", cur_col); end
    press(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    vectors++; if (occupancy !== 25'h000000E) begin miscompares++; $display("FAIL horiz_occ got %h exp 000000e", occupancy); end
    vectors++; if (ship_len !== 3'd2 || ships_left !== 3'd2) begin miscompares++; $display("FAIL horiz_counts got %0d/%0d exp 2/2", ship_len, ships_left); end
    vectors++; if ({cur_row, cur_col} !== 6'd0) begin miscompares++; $display("FAIL horiz_cursor got (%0d,%0d) exp (0,0)", cur_row, cur_col); end
  endtask

  task automatic test_out_of_bounds();
    repeat (5) press(0, 0, 0, 1, 0, 0);
    vectors++; if (cur_col !== 3'd4) begin miscompares++; $display("FAIL oob_saturate got %0d exp 4", cur_col); end
    press(0, 0, 0, 0, 0, 1);
    btn_left = 1;    // arrives during CHECK, must be dropped
    tick();
    btn_left = 0;
    vectors++; if (place_error !== 1'b1) begin miscompares++; $display("FAIL oob_error got %b exp 1", place_error); end
    tick();
    vectors++; if (place_error !== 1'b0) begin miscompares++; $display("FAIL oob_error_width got %b exp 0", place_error); end
    vectors++; if ({cur_row, cur_col} !== {3'd0, 3'd4}) begin miscompares++; $display("FAIL oob_cursor got (%0d,%0d) exp (0,4)", cur_row, cur_col); end
    vectors++; if (occupancy !== 25'h000000E) begin miscompares++; $display("FAIL oob_occ got %h exp 000000e", occupancy); end
  endtask

  task automatic test_overlap();
    press(0, 0, 1, 0, 0, 0);
    press(0, 0, 1, 0, 0, 0);
    press(0, 1, 0, 0, 1, 0);   // rot wins over down
    vectors++; if (vertical !== 1'b1 || cur_row !== 3'd0 || cur_col !== 3'd2) begin
      miscompares++; $display("FAIL rot_priority got v=%b (%0d,%0d) exp v=1 (0,2)", vertical, cur_row, cur_col);
    end
    press(0, 0, 0, 0, 0, 1);
    tick();
    vectors++; if (place_error !== 1'b1) begin miscompares++; $display("FAIL overlap_error got %b exp 1", place_error); end
    press(0, 1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    vectors++; if (occupancy !== 25'h000108E) begin miscompares++; $display("FAIL overlap_occ got %h exp 000108e", occupancy); end
    vectors++; if (ship_len !== 3'd1 || ships_left !== 3'd1 || vertical !== 1'b0) begin
      miscompares++; $display("FAIL overlap_counts got %0d/%0d v=%b exp 1/1 v=0", ship_len, ships_left, vertical);
    end
  endtask

  task automatic test_last_ship();
    repeat (4) press(0, 0, 0, 1, 0, 0);
    repeat (5) press(0, 1, 0, 0, 0, 0);
    vectors++; if ({cur_row, cur_col} !== {3'd4, 3'd4}) begin miscompares++; $display("FAIL corner_cursor got (%0d,%0d) exp (4,4)", cur_row, cur_col); end
    press(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    vectors++; if (occupancy !== 25'h100108E) begin miscompares++; $display("FAIL last_occ got %h exp 100108e", occupancy); end
    vectors++; if (done !== 1'b1 || ships_left !== 3'd0 || ship_len !== 3'd0) begin
      miscompares++; $display("FAIL last_done got done=%b left=%0d len=%0d exp 1/0/0", done, ships_left, ship_len);
    end
    start = 1;
    press(0, 0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    start = 0;
    vectors++; if (done !== 1'b1 || cur_col !== 3'd0 || occupancy !== 25'h100108E) begin
      miscompares++; $display("FAIL done_hold got done=%b col=%0d occ=%h exp 1/0/100108e", done, cur_col, occupancy);
    end
  endtask

  task automatic test_clamp_zero_priority();
    begin_fleet(3'd0);
    vectors++; if (ships_left !== 3'd1 || ship_len !== 3'd1) begin miscompares++; $display("FAIL clamp0 got %0d/%0d exp 1/1", ships_left, ship_len); end
    press(0, 0, 0, 1, 0, 1);   // ok wins over right
    tick();
    tick();
    vectors++; if (occupancy !== 25'h0000001 || done !== 1'b1) begin
      miscompares++; $display("FAIL ok_priority got occ=%h done=%b exp 0000001/1", occupancy, done);
    end
    vectors++; if (cur_col !== 3'd0) begin miscompares++; $display("FAIL ok_priority_col got %0d exp 0", cur_col); end
  endtask

  task automatic test_clamp_high_reset();
    begin_fleet(3'd7);
    vectors++; if (ships_left !== 3'd5 || ship_len !== 3'd5) begin miscompares++; $display("FAIL clamp7 got %0d/%0d exp 5/5", ships_left, ship_len); end
    press(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    vectors++; if (occupancy !== 25'h000001F || ship_len !== 3'd4 || ships_left !== 3'd4) begin
      miscompares++; $display("FAIL len5_commit got occ=%h %0d/%0d exp 000001f 4/4", occupancy, ship_len, ships_left);
    end
    press(0, 0, 0, 1, 0, 0);
    press(0, 1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1, 0);
    rst = 1;
    tick();
    vectors++; if ({cur_row, cur_col} !== 6'd0 || vertical !== 1'b0) begin
      miscompares++; $display("FAIL midreset_cursor got (%0d,%0d) v=%b exp (0,0) v=0", cur_row, cur_col, vertical);
    end
    vectors++; if (ship_len !== 3'd0 || ships_left !== 3'd0 || occupancy !== 25'h0 || done !== 1'b0 || place_error !== 1'b0) begin
      miscompares++; $display("FAIL midreset_state got len=%0d left=%0d occ=%h done=%b err=%b exp all 0",
                              ship_len, ships_left, occupancy, done, place_error);
    end
    rst = 0;
    tick();
    vectors++; if (ship_len !== 3'd0 || ships_left !== 3'd0) begin miscompares++; $display("FAIL idle_hold got %0d/%0d exp 0/0", ship_len, ships_left); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_start();
    test_horizontal();
    test_out_of_bounds();
    test_overlap();
    test_last_ship();
    test_clamp_zero_priority();
    test_clamp_high_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
